uart_rx: RTL

UART receiver that deserialises an asynchronous 8N1-style serial line into parallel words, sampling at 4x the baud rate. It consumes the `uart_clk` output of the design's UART clock divider. That signal toggles at 4x BAUD and is synchronous to `clk`, so it is used as a sample-enable and never as a clock. Received words are presented on a parallel port with a one-cycle valid strobe and a framing-error flag.

---
 rtl/uart_rx.sv | 128 ++++++++++++
 1 files changed

// File: rtl/uart_rx.sv
// UART receiver for 8N1-style frames, oversampling at 4x baud.
// uart_clk is a clk-synchronous sample enable from the divider, never used as a clock.
module uart_rx #(
    parameter int DATA_BITS = 8
) (
    input  logic                 clk,
    input  logic                 res_n,
    input  logic                 uart_clk,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data,
    output logic                 valid,
    output logic                 frame_err,
    output logic                 busy
);

    localparam int CNT_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_BITS - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t               state, state_n;
    logic                 rx_meta, rx_s;
    logic                 uart_clk_q, tick;
    logic                 armed, armed_n;
    logic [1:0]           tick_cnt, tick_cnt_n;
    logic [CNT_W-1:0]     bit_cnt, bit_cnt_n;
    logic [DATA_BITS-1:0] shreg, shreg_n, data_n;
    logic                 valid_n, frame_err_n, busy_n;

    always_ff @(posedge clk) begin
        if (!res_n) begin
            rx_meta    <= 1'b1;
            rx_s       <= 1'b1;
            uart_clk_q <= 1'b0;
        end else begin
            rx_meta    <= rx;
            rx_s       <= rx_meta;
            uart_clk_q <= uart_clk;
        end
    end

    assign tick = uart_clk & ~uart_clk_q;

    always_ff @(posedge clk) begin
        if (!res_n) begin
            state     <= IDLE;
            armed     <= 1'b0;
            tick_cnt  <= '0;
            bit_cnt   <= '0;
            shreg     <= '0;
            data      <= '0;
            valid     <= 1'b0;
            frame_err <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_n;
            armed     <= armed_n;
            tick_cnt  <= tick_cnt_n;
            bit_cnt   <= bit_cnt_n;
            shreg     <= shreg_n;
            data      <= data_n;
            valid     <= valid_n;
            frame_err <= frame_err_n;
            busy      <= busy_n;
        end
    end

    always_comb begin
        state_n     = state;
        armed_n     = armed;
        tick_cnt_n  = tick_cnt;
        bit_cnt_n   = bit_cnt;
        shreg_n     = shreg;
        data_n      = data;
        frame_err_n = frame_err;
        busy_n      = busy;
        valid_n     = 1'b0;
        if (tick) begin
            case (state)
                IDLE: begin
                    // A low line only counts as a start once a high tick has been seen.
                    if (rx_s) begin
                        armed_n = 1'b1;
                    end else if (armed) begin
                        state_n    = START;
                        tick_cnt_n = '0;
                    end
                end
                START: begin
                    if (!rx_s) begin
                        state_n    = DATA;
                        tick_cnt_n = '0;
                        bit_cnt_n  = '0;
                        busy_n     = 1'b1;
                    end else begin
                        state_n = IDLE;
                        armed_n = 1'b1;
                    end
                end
                DATA: begin
                    tick_cnt_n = tick_cnt + 2'd1;
                    if (tick_cnt == 2'd3) begin
                        shreg_n[bit_cnt] = rx_s;
                        if (bit_cnt == LAST_BIT) begin
                            state_n    = STOP;
                            tick_cnt_n = '0;
                        end else begin
                            bit_cnt_n = bit_cnt + 1'b1;
                        end
                    end
                end
                STOP: begin
                    tick_cnt_n = tick_cnt + 2'd1;
                    if (tick_cnt == 2'd3) begin
                        data_n      = shreg;
                        frame_err_n = ~rx_s;
                        valid_n     = 1'b1;
                        busy_n      = 1'b0;
                        armed_n     = rx_s;
                        state_n     = IDLE;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

endmodule
